countdown_timer: RTL

Loadable down-counter with a start/stop handshake, pause and optional auto-reload. It counts the other direction from the up-counting adders in the counter exercises. Firmware or a controlling FSM loads a start value, issues `start`, and receives a one-cycle terminal-count pulse `tc` when the count reaches zero. It sits beside the `add`-style up-counters in the counter exercise set and serves as their countdown/timeout counterpart.

---
 rtl/counter_pkg.sv | 13 +
 rtl/countdown_timer_if.sv | 29 ++
 rtl/countdown_timer.sv | 91 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter exercise set: FSM state encoding and default width.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int COUNTER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; 'state' is a debug view of the FSM.
interface countdown_timer_if #(
   parameter int WIDTH = counter_pkg::COUNTER_WIDTH_DEFAULT
);
   // Level-sampled controls: every input is taken on each rising clk edge, no handshake
   // back-pressure; start/load are simply ignored in states that do not accept them.
   logic               load;
   logic [WIDTH-1:0]   load_val;
   logic               start;
   logic               stop;
   logic               pause;
   logic               reload;
   logic [WIDTH-1:0]   count;
   logic               busy;
   logic               paused;
   logic               tc;
   logic               done;
   counter_pkg::state_e state;

   modport master (
      output load, load_val, start, stop, pause, reload,
      input  count, busy, paused, tc, done, state
   );

   modport slave (
      input  load, load_val, start, stop, pause, reload,
      output count, busy, paused, tc, done, state
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, stop and optional auto-reload from a shadow register.
module countdown_timer
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   countdown_timer_if.slave      bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             tc_q, tc_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         shadow_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         shadow_q <= shadow_d;
         tc_q     <= tc_d;
      end
   end

   // Priority on each edge: stop > load > start > pause > decrement.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      shadow_d = shadow_q;
      tc_d     = 1'b0;
      if (bus.stop) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.load) begin
                  count_d  = bus.load_val;
                  shadow_d = bus.load_val;
               end else if (bus.start && (count_q != '0)) begin
                  state_d = RUN;
               end
            end
            RUN, HOLD: begin
               if (bus.pause) begin
                  state_d = HOLD;
               end else if (count_q == WIDTH'(1)) begin
                  tc_d = 1'b1;
                  if (bus.reload) begin
                     count_d = shadow_q;
                     state_d = RUN;
                  end else begin
                     count_d = '0;
                     state_d = DONE;
                  end
               end else begin
                  state_d = RUN;
                  // Never wrap below zero even if entered with an empty count.
                  if (count_q != '0) count_d = count_q - WIDTH'(1);
               end
            end
            DONE: begin
               if (bus.load) begin
                  count_d  = bus.load_val;
                  shadow_d = bus.load_val;
                  state_d  = IDLE;
               end else if (bus.start && (shadow_q != '0)) begin
                  count_d = shadow_q;
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.count  = count_q;
      bus.tc     = tc_q;
      bus.busy   = (state_q == RUN) || (state_q == HOLD);
      bus.paused = (state_q == HOLD);
      bus.done   = (state_q == DONE);
      bus.state  = state_q;
   end

endmodule
